// File: rtl/debug_nyb_tx_if.sv
// Debug-link bundle: probe/control inputs and nybble/status outputs of debug_nyb_tx.
interface debug_nyb_tx_if;
  logic [15:0] probe;
  logic        freeze;
  logic        err_clr;
  logic [1:0]  bugsel;
  logic [3:0]  bugout;
  logic        frame;
  logic        locked;
  logic        seq_err;

  modport master (
    output probe, freeze, err_clr, bugsel,
    input  bugout, frame, locked, seq_err
  );

  modport slave (
    input  probe, freeze, err_clr, bugsel,
    output bugout, frame, locked, seq_err
  );
endinterface

// File: rtl/debug_nyb_tx.sv
// Target side of the 6-wire debug link: synchronises and filters bugsel, tracks the
// 0..3 digit sequence and serves nybbles from a snapshot that reloads only on the 3->0 wrap.
module debug_nyb_tx #(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic           C,
  input  logic           rst,
  debug_nyb_tx_if.slave  bus
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT0, TRACK} state_e;

  state_e                         state_q, state_d;
  logic [SYNC_STAGES-1:0][1:0]    sync_q, sync_d;
  logic [1:0]                     s_prev_q, s_prev_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [1:0]                     acc_sel_q, acc_sel_d;
  logic [15:0]                    snap_q, snap_d;
  logic [3:0]                     bugout_q, bugout_d;
  logic                           frame_q, frame_d;
  logic                           locked_q, locked_d;
  logic                           seq_err_q, seq_err_d;

  logic [1:0] s;
  logic       accept;
  logic       in_order;

  assign s        = sync_q[SYNC_STAGES-1];
  assign in_order = (s == 2'(acc_sel_q + 2'd1));

  // Synchroniser, glitch filter and digit output path
  always_comb begin
    sync_d    = {sync_q[SYNC_STAGES-2:0], bus.bugsel};
    s_prev_d  = s;
    cnt_d     = cnt_q;
    acc_sel_d = acc_sel_q;
    if (s != s_prev_q) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(STABLE_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    accept = (cnt_d == CNT_W'(STABLE_CYCLES)) && (s != acc_sel_q);
    if (accept) begin
      acc_sel_d = s;
    end
    bugout_d = snap_q[{acc_sel_q, 2'b00} +: 4];
  end

  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      sync_q    <= '0;
      s_prev_q  <= '0;
      cnt_q     <= '0;
      acc_sel_q <= '0;
      snap_q    <= '0;
      bugout_q  <= '0;
      frame_q   <= 1'b0;
      locked_q  <= 1'b0;
      seq_err_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      s_prev_q  <= s_prev_d;
      cnt_q     <= cnt_d;
      acc_sel_q <= acc_sel_d;
      snap_q    <= snap_d;
      bugout_q  <= bugout_d;
      frame_q   <= frame_d;
      locked_q  <= locked_d;
      seq_err_q <= seq_err_d;
    end
  end

  // FSM state register
  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: only acceptance events move it
  always_comb begin
    state_d = state_q;
    if (accept) begin
      unique case (state_q)
        IDLE:    state_d = (s == 2'd0) ? TRACK : WAIT0;
        WAIT0:   state_d = (s == 2'd0) ? TRACK : WAIT0;
        TRACK:   state_d = in_order ? TRACK : WAIT0;
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM outputs: snapshot reload, frame pulse, lock and sticky error
  always_comb begin
    logic load;
    logic err_set;
    load      = 1'b0;
    err_set   = 1'b0;
    snap_d    = snap_q;
    frame_d   = 1'b0;
    locked_d  = (state_d == TRACK);
    if (accept) begin
      if (state_q == TRACK) begin
        load    = in_order && (s == 2'd0);
        err_set = !in_order;
      end else begin
        load    = (s == 2'd0);
      end
    end
    if (load && !bus.freeze) begin
      snap_d  = bus.probe;
      frame_d = 1'b1;
    end
    seq_err_d = err_set || (seq_err_q && !bus.err_clr);
  end

  assign bus.bugout  = bugout_q;
  assign bus.frame   = frame_q;
  assign bus.locked  = locked_q;
  assign bus.seq_err = seq_err_q;

endmodule

// File: tb/tb_debug_nyb_tx.sv
// Bench for debug_nyb_tx: directed digit-select sequences, a cycle-level model and literal checks.
module tb_debug_nyb_tx;

  localparam int unsigned SYNC   = 2;
  localparam int unsigned STABLE = 4;
  localparam int unsigned HLEN   = SYNC + STABLE;

  logic C;
  logic rst;
  int   checks   = 0;
  int   failures = 0;
  int   frames   = 0;

  debug_nyb_tx_if bus ();

  debug_nyb_tx #(.SYNC_STAGES(SYNC), .STABLE_CYCLES(STABLE)) dut (
    .C   (C),
    .rst (rst),
    .bus (bus)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: bugsel history stands in for the synchroniser; a digit is taken once the
  // sample SYNC edges old has been seen unchanged for STABLE+1 consecutive edges.
  logic [1:0]  hist [HLEN];
  logic [1:0]  m_acc;
  logic [15:0] m_snap;
  logic [3:0]  m_bugout;
  logic        m_frame, m_locked, m_err;

  always @(posedge C or posedge rst) begin
    logic [1:0] cand;
    logic       stable, err_set;
    logic [3:0] nb;
    if (rst) begin
      for (int i = 0; i < int'(HLEN); i++) hist[i] = 2'd0;
      m_acc = 2'd0; m_snap = 16'h0; m_bugout = 4'h0;
      m_frame = 1'b0; m_locked = 1'b0; m_err = 1'b0;
    end else begin
      nb      = 4'((m_snap >> (4 * m_acc)) & 16'hF);
      cand    = hist[SYNC-1];
      stable  = 1'b1;
      err_set = 1'b0;
      for (int i = SYNC - 1; i < int'(HLEN); i++) if (hist[i] != cand) stable = 1'b0;
      m_frame = 1'b0;
      if (stable && cand != m_acc) begin
        if (m_locked) begin
          if (cand == 2'((m_acc + 1) % 4)) begin
            if (cand == 2'd0 && !bus.freeze) begin m_snap = bus.probe; m_frame = 1'b1; end
          end else begin
            m_locked = 1'b0;
            err_set  = 1'b1;
          end
        end else if (cand == 2'd0) begin
          m_locked = 1'b1;
          if (!bus.freeze) begin m_snap = bus.probe; m_frame = 1'b1; end
        end
        m_acc = cand;
      end
      m_err    = err_set || (m_err && !bus.err_clr);
      m_bugout = nb;
      for (int i = int'(HLEN) - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = bus.bugsel;
    end
  end

  // Cycle compare against the model, away from the active edge
  always @(negedge C) begin
    if (!rst) begin
      check("bugout",  16'(bus.bugout),  16'(m_bugout));
      check("frame",   16'(bus.frame),   16'(m_frame));
      check("locked",  16'(bus.locked),  16'(m_locked));
      check("seq_err", 16'(bus.seq_err), 16'(m_err));
      if (bus.frame) frames++;
    end
  end

  task automatic step_sel(input logic [1:0] v);
    bus.bugsel = v;
    repeat (20) @(posedge C);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    bus.probe   = 16'hA5C3;
    bus.freeze  = 1'b0;
    bus.err_clr = 1'b0;
    bus.bugsel  = 2'd3;
    repeat (3) @(posedge C);
    #1 rst = 1'b0;
    check("reset_bugout", 16'(bus.bugout), 16'h0);
    check("reset_locked", 16'(bus.locked), 16'h0);
    repeat (20) @(posedge C);
    #1;
    check("pre_locked", 16'(bus.locked), 16'h0);

    // Basic sweep
    step_sel(2'd0);
    check("t1_locked", 16'(bus.locked), 16'h1);
    check("t1_d0", 16'(bus.bugout), 16'h3);
    step_sel(2'd1); check("t1_d1", 16'(bus.bugout), 16'hC);
    step_sel(2'd2); check("t1_d2", 16'(bus.bugout), 16'h5);
    step_sel(2'd3); check("t1_d3", 16'(bus.bugout), 16'hA);
    check("t1_frames", 16'(frames), 16'd1);

    // Latency 0->1 on snapshot 1234
    bus.probe = 16'h1234;
    step_sel(2'd0);
    check("t2_d0", 16'(bus.bugout), 16'h4);
    bus.bugsel = 2'd1;
    for (int e = 0; e < 8; e++) begin
      @(posedge C);
      #1 check($sformatf("t2_lat_edge%0d", e), 16'(bus.bugout), (e < 7) ? 16'h4 : 16'h3);
    end
    repeat (20) @(posedge C);
    #1;

    // Mid-frame coherence
    bus.probe = 16'h1111;
    step_sel(2'd2); step_sel(2'd3); step_sel(2'd0); step_sel(2'd1); step_sel(2'd2);
    check("t3_d2_old", 16'(bus.bugout), 16'h1);
    bus.probe = 16'h2222;
    step_sel(2'd3); check("t3_d3_old", 16'(bus.bugout), 16'h1);
    step_sel(2'd0); check("t3_d0_new", 16'(bus.bugout), 16'h2);
    check("t3_frames", 16'(frames), 16'd4);
    step_sel(2'd1); check("t3_d1_new", 16'(bus.bugout), 16'h2);

    // Freeze across two wraps
    bus.freeze = 1'b1;
    bus.probe  = 16'h3333;
    step_sel(2'd2); step_sel(2'd3); step_sel(2'd0);
    bus.probe  = 16'h4444;
    step_sel(2'd1); step_sel(2'd2); step_sel(2'd3); step_sel(2'd0);
    check("t4_frames", 16'(frames), 16'd4);
    check("t4_d0", 16'(bus.bugout), 16'h2);
    check("t4_locked", 16'(bus.locked), 16'h1);
    bus.freeze = 1'b0;

    // Glitch rejection
    bus.probe = 16'hABCD;
    step_sel(2'd1); step_sel(2'd2); step_sel(2'd3); step_sel(2'd0); step_sel(2'd1);
    check("t5_before", 16'(bus.bugout), 16'hC);
    bus.bugsel = 2'd3;
    repeat (2) @(posedge C);
    #1 bus.bugsel = 2'd1;
    repeat (20) @(posedge C);
    #1;
    check("t5_bugout", 16'(bus.bugout), 16'hC);
    check("t5_seq_err", 16'(bus.seq_err), 16'h0);
    check("t5_locked", 16'(bus.locked), 16'h1);

    // Out-of-order, relock, error clear, async reset
    bus.probe = 16'h5678;
    step_sel(2'd2); step_sel(2'd3); step_sel(2'd0);
    check("t6_d0", 16'(bus.bugout), 16'h8);
    step_sel(2'd1); step_sel(2'd3);
    check("t6_seq_err", 16'(bus.seq_err), 16'h1);
    check("t6_unlocked", 16'(bus.locked), 16'h0);
    check("t6_d3", 16'(bus.bugout), 16'h5);
    bus.probe = 16'h9ABC;
    step_sel(2'd0);
    check("t6_relock", 16'(bus.locked), 16'h1);
    check("t6_reload", 16'(bus.bugout), 16'hC);
    check("t6_err_held", 16'(bus.seq_err), 16'h1);
    check("t6_frames", 16'(frames), 16'd7);
    bus.err_clr = 1'b1;
    @(posedge C);
    #1 bus.err_clr = 1'b0;
    check("t6_err_clr", 16'(bus.seq_err), 16'h0);
    bus.bugsel = 2'd1;
    repeat (3) @(posedge C);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_bugout", 16'(bus.bugout), 16'h0);
    check("t6_rst_frame", 16'(bus.frame), 16'h0);
    check("t6_rst_locked", 16'(bus.locked), 16'h0);
    check("t6_rst_seq_err", 16'(bus.seq_err), 16'h0);
    repeat (3) @(posedge C);
    #1 rst = 1'b0;
    repeat (30) @(posedge C);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
